// File: rtl/cond_unit_pkg.sv
// Shared definitions for the conditional-execution unit.
// cond_e     : ARM condition-code encoding (NV = never).
// FLAG_*     : bit positions of Z/N/C/V in the flag vector.
// FLAGW_*    : bit positions of the per-group flag write mask.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE,
    NV = 4'hF
  } cond_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FLAGW_ZN = 1;
  localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_unit_if.sv
// Handshake/data bundle for cond_unit.
// Input side : in_valid/in_ready, Cond, FlagW, PCS/RegW/MemW, ALUFlags, ALUResult.
// Output side: out_valid/out_ready, PCSrc/RegWrite/MemWrite, CondEx, Result,
//              Flags (architectural flag register), SquashCnt.
// slave  : the unit's view.  master : the surrounding pipeline's view.
interface cond_unit_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   Cond;
  logic [1:0]   FlagW;
  logic         PCS;
  logic         RegW;
  logic         MemW;
  logic [3:0]   ALUFlags;
  logic [N-1:0] ALUResult;

  logic         out_valid;
  logic         out_ready;
  logic         PCSrc;
  logic         RegWrite;
  logic         MemWrite;
  logic         CondEx;
  logic [N-1:0] Result;
  logic [3:0]   Flags;
  logic [15:0]  SquashCnt;

  modport slave (
    input  in_valid, Cond, FlagW, PCS, RegW, MemW, ALUFlags, ALUResult, out_ready,
    output in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Result, Flags,
           SquashCnt
  );

  modport master (
    output in_valid, Cond, FlagW, PCS, RegW, MemW, ALUFlags, ALUResult, out_ready,
    input  in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Result, Flags,
           SquashCnt
  );
endinterface

// File: rtl/cond_unit_eval.sv
// Combinational condition-code evaluator.
// Cond   : 4-bit ARM condition code.
// Flags  : current flag register {Z,N,C,V}.
// CondEx : 1 when the condition passes; code F never passes.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic z, n, c, v;

  assign z = Flags[FLAG_Z];
  assign n = Flags[FLAG_N];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (cond_e'(Cond))
      EQ:      CondEx = z;
      NE:      CondEx = !z;
      CS:      CondEx = c;
      CC:      CondEx = !c;
      MI:      CondEx = n;
      PL:      CondEx = !n;
      VS:      CondEx = v;
      VC:      CondEx = !v;
      HI:      CondEx = c && !z;
      LS:      CondEx = !c || z;
      GE:      CondEx = (n == v);
      LT:      CondEx = (n != v);
      GT:      CondEx = !z && (n == v);
      LE:      CondEx = z || (n != v);
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit between execute and writeback.
// Holds the architectural flag register, evaluates each instruction's
// condition against it, gates write-side controls, updates flags under the
// FlagW group mask and presents the result through a one-entry valid/ready
// output register.
// clk   : rising-edge clock.
// rst_n : asynchronous active-low reset.
// bus   : cond_unit_if slave port (input handshake, output register, Flags,
//         SquashCnt).
module cond_unit
  import cond_pkg::*;
#(
  parameter int N = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  cond_unit_if.slave  bus
);

  logic         cond_ex;
  logic         in_ready;
  logic         accept;

  logic         out_valid_q;
  logic         cond_ex_q;
  logic         pcsrc_q;
  logic         reg_write_q;
  logic         mem_write_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;
  logic [15:0]  squash_q;

  // Evaluated against the flags before this instruction; an update from the
  // previous accept is already in flags_q, so dependent instructions issue
  // back-to-back.
  cond_eval u_eval (
    .Cond   (bus.Cond),
    .Flags  (flags_q),
    .CondEx (cond_ex)
  );

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      cond_ex_q   <= 1'b0;
      pcsrc_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      squash_q    <= '0;
    end else if (accept) begin
      // Covers the simultaneous drain-and-accept case: the new entry simply
      // overwrites the one being drained and out_valid stays set.
      out_valid_q <= 1'b1;
      cond_ex_q   <= cond_ex;
      pcsrc_q     <= bus.PCS  && cond_ex;
      reg_write_q <= bus.RegW && cond_ex;
      mem_write_q <= bus.MemW && cond_ex;
      result_q    <= bus.ALUResult;
      if (cond_ex) begin
        if (bus.FlagW[FLAGW_ZN]) begin
          flags_q[FLAG_Z] <= bus.ALUFlags[FLAG_Z];
          flags_q[FLAG_N] <= bus.ALUFlags[FLAG_N];
        end
        if (bus.FlagW[FLAGW_CV]) begin
          flags_q[FLAG_C] <= bus.ALUFlags[FLAG_C];
          flags_q[FLAG_V] <= bus.ALUFlags[FLAG_V];
        end
      end else if (squash_q != '1) begin
        squash_q <= squash_q + 16'd1;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.CondEx    = cond_ex_q;
  assign bus.PCSrc     = pcsrc_q;
  assign bus.RegWrite  = reg_write_q;
  assign bus.MemWrite  = mem_write_q;
  assign bus.Result    = result_q;
  assign bus.Flags     = flags_q;
  assign bus.SquashCnt = squash_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed stimulus, scoreboard queue
// filled at issue time, monitor compares every drained output entry.
module tb_cond_unit;

  logic clk;
  logic rst_n;

  cond_unit_if #(.N(32)) bus ();

  cond_unit #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        condex;
    logic        pcsrc;
    logic        regw;
    logic        memw;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [15:0] sq;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0]  mflags;
  logic [15:0] msq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Pass mask per condition code, indexed by the flag value {Z,N,C,V}.
  function automatic logic [15:0] cond_mask(input logic [3:0] c);
    case (c)
      4'h0: return 16'hFF00;
      4'h1: return 16'h00FF;
      4'h2: return 16'hCCCC;
      4'h3: return 16'h3333;
      4'h4: return 16'hF0F0;
      4'h5: return 16'h0F0F;
      4'h6: return 16'hAAAA;
      4'h7: return 16'h5555;
      4'h8: return 16'h00CC;
      4'h9: return 16'hFF33;
      4'hA: return 16'hA5A5;
      4'hB: return 16'h5A5A;
      4'hC: return 16'h00A5;
      4'hD: return 16'hFF5A;
      4'hE: return 16'hFFFF;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic drive(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                       input logic regw, input logic memw, input logic [3:0] af,
                       input logic [31:0] res);
    bus.Cond      = c;
    bus.FlagW     = fw;
    bus.PCS       = pcs;
    bus.RegW      = regw;
    bus.MemW      = memw;
    bus.ALUFlags  = af;
    bus.ALUResult = res;
    bus.in_valid  = 1'b1;
  endtask

  // Model the currently driven instruction and queue its expected output.
  task automatic commit();
    exp_t        e;
    logic [15:0] m;
    m = cond_mask(bus.Cond);
    e.condex = m[mflags];
    e.pcsrc  = bus.PCS  & e.condex;
    e.regw   = bus.RegW & e.condex;
    e.memw   = bus.MemW & e.condex;
    e.result = bus.ALUResult;
    if (e.condex) begin
      if (bus.FlagW[1]) mflags[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagW[0]) mflags[1:0] = bus.ALUFlags[1:0];
    end else if (msq != 16'hFFFF) begin
      msq = msq + 16'd1;
    end
    e.flags = mflags;
    e.sq    = msq;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] c, input logic [1:0] fw, input logic pcs,
                      input logic regw, input logic memw, input logic [3:0] af,
                      input logic [31:0] res);
    int k;
    @(negedge clk);
    drive(c, fw, pcs, regw, memw, af, res);
    #1;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!bus.in_ready) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    commit();
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: samples mid-cycle, after the driver has settled its inputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 32'(bus.out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("CondEx",    32'(bus.CondEx),    32'(e.condex));
          chk("PCSrc",     32'(bus.PCSrc),     32'(e.pcsrc));
          chk("RegWrite",  32'(bus.RegWrite),  32'(e.regw));
          chk("MemWrite",  32'(bus.MemWrite),  32'(e.memw));
          chk("Result",    bus.Result,         e.result);
          chk("Flags",     32'(bus.Flags),     32'(e.flags));
          chk("SquashCnt", 32'(bus.SquashCnt), 32'(e.sq));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res_a;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0);
    bus.in_valid  = 1'b0;
    mflags        = 4'b0000;
    msq           = 16'd0;

    // Reset state
    #7;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_Flags",     32'(bus.Flags),     32'd0);
    chk("rst_SquashCnt", 32'(bus.SquashCnt), 32'd0);
    chk("rst_Result",    bus.Result,         32'd0);
    chk("rst_CondEx",    32'(bus.CondEx),    32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // AL, FlagW=11, ALUFlags=1000, RegW=1
    send(4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h0000_1111);
    #1;
    chk("al_out_valid", 32'(bus.out_valid), 32'd1);
    chk("al_RegWrite",  32'(bus.RegWrite),  32'd1);
    chk("al_Flags",     32'(bus.Flags),     32'b1000);

    // EQ then NE back-to-back with Z=1
    send(4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_2222);
    #1;
    chk("eq_RegWrite", 32'(bus.RegWrite), 32'd1);
    send(4'h1, 2'b00, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0000_3333);
    #1;
    chk("ne_RegWrite",  32'(bus.RegWrite),  32'd0);
    chk("ne_SquashCnt", 32'(bus.SquashCnt), 32'd1);

    // Partial flag write: only Z,N group
    send(4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0000_4444);
    send(4'hE, 2'b10, 1'b0, 1'b0, 1'b0, 4'b0111, 32'h0000_5555);
    #1;
    chk("mask_Flags", 32'(bus.Flags), 32'b0100);

    // Stall: out_ready low for 3 cycles with a pending instruction
    idle();
    wait_drain();
    @(negedge clk);
    bus.out_ready = 1'b0;
    res_a = 32'hA5A5_0001;
    send(4'hE, 2'b00, 1'b1, 1'b1, 1'b1, 4'b0000, res_a);
    @(negedge clk);
    drive(4'hE, 2'b11, 1'b0, 1'b1, 1'b0, 4'b1010, 32'hA5A5_0002);
    #1;
    repeat (3) begin
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_Result",    bus.Result,         res_a);
      chk("stall_Flags",     32'(bus.Flags),     32'b0100);
      @(negedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    #0;
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    commit();
    @(posedge clk);
    #1;
    chk("swap_out_valid", 32'(bus.out_valid), 32'd1);
    chk("swap_Result",    bus.Result,         32'hA5A5_0002);
    chk("swap_Flags",     32'(bus.Flags),     32'b1010);
    idle();
    wait_drain();

    // Sweep all codes against all flag values; NV also tries to write flags
    for (int f = 0; f < 16; f++) begin
      send(4'hE, 2'b11, 1'b0, 1'b0, 1'b0, 4'(f), 32'(f));
      for (int c = 0; c < 15; c++) begin
        send(4'(c), 2'b00, 1'b1, 1'b1, 1'b1, 4'h0, 32'(f * 16 + c) ^ 32'h5A00_0000);
      end
      send(4'hF, 2'b11, 1'b1, 1'b1, 1'b1, ~4'(f), 32'hF0F0_0000 | 32'(f));
    end
    idle();
    wait_drain();

    // Reset asserted mid-stall with a pending entry and all flags set
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(4'hE, 2'b11, 1'b1, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    #1;
    chk("prerst_out_valid", 32'(bus.out_valid), 32'd1);
    chk("prerst_Flags",     32'(bus.Flags),     32'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_Flags",     32'(bus.Flags),     32'd0);
    chk("arst_Result",    bus.Result,         32'd0);
    chk("arst_CondEx",    32'(bus.CondEx),    32'd0);
    chk("arst_PCSrc",     32'(bus.PCSrc),     32'd0);
    chk("arst_RegWrite",  32'(bus.RegWrite),  32'd0);
    chk("arst_MemWrite",  32'(bus.MemWrite),  32'd0);
    chk("arst_SquashCnt", 32'(bus.SquashCnt), 32'd0);
    sb.delete();
    mflags = 4'b0000;
    msq    = 16'd0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
# cond_unit

Conditional-execution unit that consumes the `{Z,N,C,V}` flags and result produced by `ALU_N_bits`. It holds the architectural flag register and evaluates each instruction's 4-bit condition code against it. It gates the instruction's write-side controls and updates the flags under a per-group write mask. It sits between execute and writeback behind a one-entry valid/ready output register.

## Interface
- `N`, 32, datapath width of the forwarded ALU result
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  instruction + ALU outputs present
- `in_ready`  out  1  unit can accept this cycle
- `Cond`  in  4  condition code (ARM encoding)
- `FlagW`  in  2  [1]: write Z,N; [0]: write C,V
- `PCS`, `RegW`, `MemW`  in  1 each  ungated controls
- `ALUFlags`  in  4  bit3 Z, bit2 N, bit1 C, bit0 V
- `ALUResult`  in  N  ALU RESULT
- `out_valid`  out  1  registered output valid
- `out_ready`  in  1  downstream accepts
- `PCSrc`, `RegWrite`, `MemWrite`  out  1 each  gated controls
- `CondEx`  out  1  condition passed
- `Result`  out  N  registered ALUResult
- `Flags`  out  4  architectural flag register, same bit order
- `SquashCnt`  out  16  count of failed-condition instructions, saturating

## Operation
- Accept event: `in_valid && in_ready`. Nothing is sampled otherwise.
- `in_ready = !out_valid || out_ready`. This is combinational and has no dependence on `in_valid`.
- Condition evaluation is combinational from `Cond` and `Flags`, i.e. the flags before this instruction.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: treated as never, CondEx=0
- On accept:
  - Output register loads `CondEx`, `PCSrc=PCS&CondEx`, `RegWrite=RegW&CondEx`, `MemWrite=MemW&CondEx`, `Result=ALUResult`.
  - `out_valid` is set to 1.
- On accept with CondEx=1:
  - `Flags[3:2]<=ALUFlags[3:2]` if `FlagW[1]`.
  - `Flags[1:0]<=ALUFlags[1:0]` if `FlagW[0]`.
  - Bits in an unmasked group hold.
- On accept with CondEx=0: no flag change, and `SquashCnt` increments, saturating at 16'hFFFF.
- With no accept, `out_valid` clears when `out_ready` is high; otherwise the output register holds all fields stable.
- Simultaneous drain and accept (`out_valid && out_ready && in_valid`): the new entry replaces the old in the same edge and `out_valid` stays 1.
- X on `Cond`/`FlagW` while `in_valid=0` has no effect.

## Timing
- Reset (async assert, sync-released by the top level):
  - `Flags=4'b0000`, `out_valid=0`, `CondEx=0`, `PCSrc=RegWrite=MemWrite=0`, `Result=0`, `SquashCnt=0`.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle while `out_ready=1`.
- Flag forwarding:
  - An instruction accepted at edge k updates `Flags` at edge k.
  - The instruction accepted at edge k+1 evaluates against the updated value, so back-to-back dependent instructions need no bubble.
- `Flags` and `SquashCnt` change only on accept edges.
- Reset mid-stall: the pending output is discarded and the flag history is lost. There is no replay.

## Structure
- Package `cond_pkg`:
  - `cond_e` enum (EQ..AL, NV).
  - Localparams `FLAG_Z=3`, `FLAG_N=2`, `FLAG_C=1`, `FLAG_V=0`.
  - Localparams `FLAGW_ZN=1`, `FLAGW_CV=0`.
- Sub-module `cond_eval` (combinational):
  - Inputs: `Cond`, `Flags`. Output: `CondEx`.
  - The top holds the flag register, the output register, the handshake and the counter.

## Test plan
- After reset, AL, FlagW=11, ALUFlags=1000, RegW=1 -> next cycle `out_valid=1`, `RegWrite=1`, `Flags=1000`.
- Flags=1000, EQ then NE back-to-back, both RegW=1 -> RegWrite 1 then 0; `SquashCnt=1`.
- Flags=0000, FlagW=10, ALUFlags=0111 with AL -> `Flags=0100`, C and V unchanged.
- Hold `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0`, outputs and `Flags` stable. Then raise `out_ready` -> drain and accept on the same edge.
- Sweep all 16 codes × 16 flag values against the table; code F -> CondEx=0, MemWrite=0, flags unchanged.
- Assert `rst_n` low mid-stall with `out_valid=1` and Flags=1111 -> all outputs 0 immediately, without waiting for a clock edge.
